// File: rtl/lift_request_queue_pkg.sv
// Shared lift definitions: request codes, button indices, queue depth and
// small helpers for converting between button indices and request codes.
package lift_pkg;

  localparam int NUM_BTN = 6;
  localparam int DEPTH   = 6;

  typedef logic [2:0] code_t;
  typedef logic [2:0] ptr_t;

  localparam code_t CODE_NONE = 3'b000;
  localparam code_t CODE_1U   = 3'b001;
  localparam code_t CODE_2U   = 3'b010;
  localparam code_t CODE_3U   = 3'b011;
  localparam code_t CODE_2D   = 3'b110;
  localparam code_t CODE_3D   = 3'b111;
  localparam code_t CODE_4D   = 3'b100;

  localparam int IDX_1U = 0;
  localparam int IDX_2U = 1;
  localparam int IDX_3U = 2;
  localparam int IDX_2D = 3;
  localparam int IDX_3D = 4;
  localparam int IDX_4D = 5;

  localparam ptr_t PTR_LAST = 3'(DEPTH - 1);

  function automatic code_t idx_to_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return CODE_1U;
      3'd1:    return CODE_2U;
      3'd2:    return CODE_3U;
      3'd3:    return CODE_2D;
      3'd4:    return CODE_3D;
      3'd5:    return CODE_4D;
      default: return CODE_NONE;
    endcase
  endfunction

  function automatic logic [NUM_BTN-1:0] code_to_mask(input code_t code);
    case (code)
      CODE_1U: return 6'b000001;
      CODE_2U: return 6'b000010;
      CODE_3U: return 6'b000100;
      CODE_2D: return 6'b001000;
      CODE_3D: return 6'b010000;
      CODE_4D: return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  // Depth is not a power of two, so pointers wrap by explicit compare.
  function automatic ptr_t wrap_inc(input ptr_t p);
    return (p == PTR_LAST) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/lift_request_queue_if.sv
// Hall-call bus between the button panel / lift controller and the queue.
interface lift_request_queue_if;
  import lift_pkg::*;

  logic [NUM_BTN-1:0] btn;
  logic               ready;
  code_t              req_code;
  logic               q_empty;
  logic [NUM_BTN-1:0] pending;

  modport master (output btn, ready, input req_code, q_empty, pending);
  modport slave  (input btn, ready, output req_code, q_empty, pending);
endinterface

// File: rtl/lift_btn_sync.sv
// Per-button 2-flop synchroniser followed by a rising-edge detector. A button
// held through reset is masked until it has been seen released.
module lift_btn_sync
  import lift_pkg::*;
#(
  parameter int WIDTH = NUM_BTN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] prev_p2;
  logic [WIDTH-1:0] armed;
  logic [1:0]       fill;

  // Synchronise, keep previous sample, and arm each bit once it reads low
  // after the synchroniser has refilled (fill[1]) following reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '1;
      armed   <= '0;
      fill    <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      fill    <= {fill[0], 1'b1};
      if (fill[1]) begin
        armed <= armed | ~sync_p1;
      end
    end
  end

  assign rise = sync_p1 & ~prev_p2 & armed;

endmodule

// File: rtl/lift_request_queue.sv
// Hall-call request queue: captures button edges with deduplication,
// enqueues one code per cycle (lowest index first) into a 6-entry circular
// FIFO, and issues the head to the lift controller with an idle gap between
// consecutive issues.
module lift_request_queue
  import lift_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  lift_request_queue_if.slave  bus
);

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] cap;
  logic [NUM_BTN-1:0] pending_q;
  code_t              mem [DEPTH];
  ptr_t               wr_ptr;
  ptr_t               rd_ptr;
  logic [2:0]         count;
  code_t              req_code_q;
  logic               issued_q;

  logic               do_enq;
  logic               do_pop;
  logic [2:0]         enq_idx;
  code_t              enq_code;
  logic [NUM_BTN-1:0] enq_mask;
  code_t              head;
  logic [NUM_BTN-1:0] iss_mask;
  logic [NUM_BTN-1:0] accept;

  lift_btn_sync #(.WIDTH(NUM_BTN)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn),
    .rise  (rise)
  );

  // Pick the lowest captured button, decide issue, and qualify new edges.
  always_comb begin
    enq_idx = 3'd0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (cap[i]) begin
        enq_idx = 3'(i);
      end
    end
    do_enq   = |cap;
    enq_code = idx_to_code(enq_idx);
    enq_mask = do_enq ? (6'b000001 << enq_idx) : '0;
    head     = mem[rd_ptr];
    do_pop   = bus.ready && (count != 3'd0) && !issued_q;
    iss_mask = do_pop ? code_to_mask(head) : '0;
    // An edge on a button whose code is issued this cycle is a fresh request.
    accept   = rise & (~pending_q | iss_mask);
  end

  // Control state: capture/pending lamps, pointers, occupancy, issue output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap        <= '0;
      pending_q  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      req_code_q <= CODE_NONE;
      issued_q   <= 1'b0;
    end else begin
      cap        <= (cap & ~enq_mask) | accept;
      pending_q  <= (pending_q & ~iss_mask) | accept;
      req_code_q <= do_pop ? head : CODE_NONE;
      issued_q   <= do_pop;
      if (do_enq) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      case ({do_enq, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage: data only, never needs a reset value.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_code;
    end
  end

  assign bus.req_code = req_code_q;
  assign bus.pending  = pending_q;
  assign bus.q_empty  = (count == 3'd0);

endmodule

// File: tb/tb_lift_request_queue.sv
// Directed bench for lift_request_queue with a scoreboard of expected issue
// codes and an independent monitor that pops and compares on every issue.
module tb_lift_request_queue;

  logic clk = 1'b0;
  logic rst_n;

  lift_request_queue_if bus ();

  lift_request_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_q[$];
  logic [2:0] code_tb [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
  logic [2:0] last_code = 3'b000;
  logic [5:0] patterns [4] = '{6'b111111, 6'b101101, 6'b011110, 6'b111111};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pattern(input logic [5:0] m);
    for (int i = 0; i < 6; i++) begin
      if (m[i]) exp_q.push_back(code_tb[i]);
    end
  endtask

  task automatic press(input logic [5:0] m, input int hold);
    bus.btn = m;
    repeat (hold) @(negedge clk);
    bus.btn = 6'b000000;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every non-idle req_code must match the scoreboard head and be
  // preceded by an idle cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.req_code != 3'b000) begin
        check("issue_gap", 32'(last_code), 0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got %b expected no issue", bus.req_code);
        end else begin
          check("issue_order", 32'(bus.req_code), 32'(exp_q.pop_front()));
        end
      end
      last_code = bus.req_code;
    end else begin
      last_code = 3'b000;
    end
  end

  initial begin
    bus.btn   = 6'b000000;
    bus.ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_code", 32'(bus.req_code), 0);
    check("reset_q_empty", 32'(bus.q_empty), 1);
    check("reset_pending", 32'(bus.pending), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single press with latency profile, ready high.
    bus.ready = 1'b1;
    exp_q.push_back(3'b010);
    bus.btn = 6'b000010;
    @(posedge clk);
    @(posedge clk); #1;
    check("lat_n1_req", 32'(bus.req_code), 0);
    @(posedge clk); #1;
    check("lat_n2_pending", 32'(bus.pending), 32'(6'b000010));
    bus.btn = 6'b000000;
    @(posedge clk); #1;
    check("lat_n3_q_empty", 32'(bus.q_empty), 0);
    check("lat_n3_req", 32'(bus.req_code), 0);
    @(posedge clk); #1;
    check("lat_n4_req", 32'(bus.req_code), 32'(3'b010));
    @(posedge clk); #1;
    check("lat_n5_req", 32'(bus.req_code), 0);
    check("lat_n5_pending", 32'(bus.pending), 0);
    check("lat_n5_q_empty", 32'(bus.q_empty), 1);
    @(negedge clk);

    // Deduplication: 4D, 1U, 4D again with ready low.
    bus.ready = 1'b0;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    press(6'b100000, 2);
    press(6'b000001, 2);
    press(6'b100000, 2);
    repeat (3) @(negedge clk);
    check("dedup_pending", 32'(bus.pending), 32'(6'b100001));
    check("dedup_q_empty", 32'(bus.q_empty), 0);
    bus.ready = 1'b1;
    repeat (10) @(negedge clk);
    check("dedup_drain_pending", 32'(bus.pending), 0);
    check("dedup_drain_q_empty", 32'(bus.q_empty), 1);

    // All six buttons in one cycle.
    bus.ready = 1'b0;
    push_pattern(6'b111111);
    press(6'b111111, 2);
    repeat (5) @(negedge clk);
    check("all6_pending", 32'(bus.pending), 32'(6'b111111));
    check("all6_q_empty", 32'(bus.q_empty), 0);
    bus.ready = 1'b1;
    repeat (14) @(negedge clk);
    check("all6_drain_q_empty", 32'(bus.q_empty), 1);
    check("all6_drain_pending", 32'(bus.pending), 0);

    // Repeated fill/drain with a re-press mid-drain; pointers wrap.
    for (int r = 0; r < 4; r++) begin
      logic [5:0] low;
      bus.ready = 1'b0;
      push_pattern(patterns[r]);
      press(patterns[r], 2);
      repeat (6) @(negedge clk);
      bus.ready = 1'b1;
      repeat (3) @(negedge clk);
      low = patterns[r] & (~patterns[r] + 6'b000001);
      push_pattern(low);
      press(low, 2);
      repeat (14) @(negedge clk);
      check("wrap_round_q_empty", 32'(bus.q_empty), 1);
    end

    // Reset mid-operation with btn[2] held through it.
    bus.ready = 1'b0;
    press(6'b001011, 2);
    repeat (4) @(negedge clk);
    check("rst_pre_q_empty", 32'(bus.q_empty), 0);
    bus.btn = 6'b000100;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_req_code", 32'(bus.req_code), 0);
    check("rst_mid_q_empty", 32'(bus.q_empty), 1);
    check("rst_mid_pending", 32'(bus.pending), 0);
    bus.ready = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_held_pending", 32'(bus.pending), 0);
    check("rst_held_q_empty", 32'(bus.q_empty), 1);
    bus.btn = 6'b000000;
    repeat (4) @(negedge clk);
    exp_q.push_back(3'b011);
    press(6'b000100, 2);
    repeat (8) @(negedge clk);
    check("rst_repress_pending", 32'(bus.pending), 0);
    check("rst_repress_q_empty", 32'(bus.q_empty), 1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
